keystroke_sequencer: RTL and testbench

KEYSTROKE_SEQUENCER -- requirements
Module: keystroke_sequencer

---
 rtl/keystroke_sequencer.sv | 131 +++++++++++++
 tb/tb_keystroke_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keystroke_sequencer.sv
// Turns a PS/2 scan-code stream into a buffered word of letters a..z.
// Make codes are latched for an external decoder; ENTR commits the word to a consumer.
module keystroke_sequencer #(
  parameter int MAX_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           scan_byte,
  input  logic                 scan_valid,
  output logic [3:0]           dig1,
  output logic [3:0]           dig2,
  input  logic [4:0]           letter_code,
  output logic [5*MAX_LEN-1:0] word_data,
  output logic [3:0]           word_len,
  output logic                 word_valid,
  input  logic                 word_ack,
  output logic                 key_drop
);

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BKSP  = 8'h66;
  localparam logic [4:0] CODE_ENTR  = 5'd31;
  localparam logic [4:0] CODE_LAST  = 5'd25;
  localparam logic [3:0] LEN_MAX    = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, LOOKUP} state_t;

  state_t     state, state_next;
  logic [7:0] code, code_next;
  logic [4:0] buffer      [MAX_LEN];
  logic [4:0] buffer_next [MAX_LEN];
  logic [3:0] len_next;
  logic       valid_next;
  logic       drop_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= '0;
      word_len   <= '0;
      word_valid <= 1'b0;
      key_drop   <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) buffer[k] <= '0;
    end else begin
      state      <= state_next;
      code       <= code_next;
      word_len   <= len_next;
      word_valid <= valid_next;
      key_drop   <= drop_next;
      for (int k = 0; k < MAX_LEN; k++) buffer[k] <= buffer_next[k];
    end
  end

  // Entries above word_len are zeroed whenever the length shrinks, so packing needs no mask.
  always_comb begin
    word_data = '0;
    for (int k = 0; k < MAX_LEN; k++) word_data[5*k +: 5] = buffer[k];
  end

  assign dig2 = code[7:4];
  assign dig1 = code[3:0];

  always_comb begin
    state_next  = state;
    code_next   = code;
    buffer_next = buffer;
    len_next    = word_len;
    valid_next  = word_valid;
    drop_next   = 1'b0;

    case (state)
      IDLE: begin
        if (scan_valid) begin
          case (scan_byte)
            BYTE_BREAK: state_next = BREAK;
            BYTE_EXT:   state_next = EXT;
            BYTE_BKSP: begin
              if (word_valid) begin
                drop_next = 1'b1;
              end else if (word_len != 4'd0) begin
                len_next = word_len - 4'd1;
                for (int k = 0; k < MAX_LEN; k++)
                  if (k == int'(word_len) - 1) buffer_next[k] = '0;
              end
            end
            default: begin
              code_next  = scan_byte;
              state_next = LOOKUP;
            end
          endcase
        end
      end

      BREAK: begin
        if (scan_valid) state_next = IDLE;
      end

      EXT: begin
        if (scan_valid) state_next = (scan_byte == BYTE_BREAK) ? BREAK : IDLE;
      end

      // A byte arriving while the decoder result is being consumed is lost.
      LOOKUP: begin
        state_next = IDLE;
        if (scan_valid) drop_next = 1'b1;
        if (letter_code <= CODE_LAST) begin
          if (word_valid || word_len == LEN_MAX) begin
            drop_next = 1'b1;
          end else begin
            len_next = word_len + 4'd1;
            for (int k = 0; k < MAX_LEN; k++)
              if (k == int'(word_len)) buffer_next[k] = letter_code;
          end
        end else if (letter_code == CODE_ENTR) begin
          if (word_valid) drop_next = 1'b1;
          else if (word_len != 4'd0) valid_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (word_valid && word_ack) begin
      valid_next = 1'b0;
      len_next   = '0;
      for (int k = 0; k < MAX_LEN; k++) buffer_next[k] = '0;
    end
  end

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Self-checking bench: directed scenarios with literal checks, then random scan traffic
// compared every cycle against a queue-based behavioural model.
module tb_keystroke_sequencer;

  localparam int MAX_LEN = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [7:0]           scan_byte;
  logic                 scan_valid;
  logic [3:0]           dig1, dig2;
  logic [4:0]           letter_code;
  logic [5*MAX_LEN-1:0] word_data;
  logic [3:0]           word_len;
  logic                 word_valid;
  logic                 word_ack;
  logic                 key_drop;

  int vectors     = 0;
  int miscompares = 0;
  int drop_count  = 0;

  logic [7:0] letters [8] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};

  logic [4:0] m_q [$];
  logic       m_valid  = 1'b0;
  logic       m_drop   = 1'b0;
  logic       m_lookup = 1'b0;
  logic [7:0] m_prefix = 8'h00;
  logic [7:0] m_code   = 8'h00;

  keystroke_sequencer #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .dig1(dig1), .dig2(dig2), .letter_code(letter_code), .word_data(word_data),
    .word_len(word_len), .word_valid(word_valid), .word_ack(word_ack), .key_drop(key_drop)
  );

  always #5 clk = ~clk;

  // Stand-in for the external keycode decoder.
  function automatic logic [4:0] decode(input logic [7:0] b);
    case (b)
      8'h1C: return 5'd0;
      8'h32: return 5'd1;
      8'h21: return 5'd2;
      8'h23: return 5'd3;
      8'h24: return 5'd4;
      8'h2B: return 5'd5;
      8'h34: return 5'd6;
      8'h33: return 5'd7;
      8'h5A: return 5'd31;
      8'h0E: return 5'd27;
      8'h16: return 5'd30;
      default: return 5'd29;
    endcase
  endfunction

  assign letter_code = decode({dig2, dig1});

  function automatic logic [5*MAX_LEN-1:0] pack_model();
    logic [5*MAX_LEN-1:0] r = '0;
    for (int k = 0; k < m_q.size(); k++) r[5*k +: 5] = m_q[k];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid  = 1'b0;
    m_drop   = 1'b0;
    m_lookup = 1'b0;
    m_prefix = 8'h00;
    m_code   = 8'h00;
  endtask

  // One clock of the behaviour: a pending decoder lookup, a pending prefix, or a fresh byte.
  task automatic model_step();
    logic       old_valid;
    logic       drop;
    logic [4:0] lc;
    old_valid = m_valid;
    drop = 1'b0;
    if (m_lookup) begin
      m_lookup = 1'b0;
      lc = decode(m_code);
      if (scan_valid) drop = 1'b1;
      if (lc <= 5'd25) begin
        if (old_valid || m_q.size() == MAX_LEN) drop = 1'b1;
        else m_q.push_back(lc);
      end else if (lc == 5'd31) begin
        if (old_valid) drop = 1'b1;
        else if (m_q.size() > 0) m_valid = 1'b1;
      end
    end else if (m_prefix == 8'hF0) begin
      if (scan_valid) m_prefix = 8'h00;
    end else if (m_prefix == 8'hE0) begin
      if (scan_valid) m_prefix = (scan_byte == 8'hF0) ? 8'hF0 : 8'h00;
    end else if (scan_valid) begin
      if (scan_byte == 8'hF0 || scan_byte == 8'hE0) begin
        m_prefix = scan_byte;
      end else if (scan_byte == 8'h66) begin
        if (old_valid) drop = 1'b1;
        else if (m_q.size() > 0) void'(m_q.pop_back());
      end else begin
        m_code   = scan_byte;
        m_lookup = 1'b1;
      end
    end
    if (old_valid && word_ack) begin
      m_q.delete();
      m_valid = 1'b0;
    end
    m_drop = drop;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  // Compare every output against the model half a cycle after each active edge.
  always @(negedge clk) begin
    if (key_drop === 1'b1) drop_count++;
    check("dig1", 64'(dig1), 64'(m_code[3:0]));
    check("dig2", 64'(dig2), 64'(m_code[7:4]));
    check("word_len", 64'(word_len), 64'(m_q.size()));
    check("word_data", 64'(word_data), 64'(pack_model()));
    check("word_valid", 64'(word_valid), 64'(m_valid));
    check("key_drop", 64'(key_drop), 64'(m_drop));
  end

  // Inputs change just after a falling edge and are sampled on the following rising edge.
  task automatic applyStimulus(input logic sv, input logic [7:0] sb, input logic ack);
    @(negedge clk);
    #1;
    scan_valid = sv;
    scan_byte  = sb;
    word_ack   = ack;
  endtask

  task automatic sendKey(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic settle();
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int len, input logic [63:0] data,
                             input logic valid);
    check({name, "_len"}, 64'(word_len), 64'(len));
    check({name, "_data"}, 64'(word_data), data);
    check({name, "_valid"}, 64'(word_valid), 64'(valid));
    check({name, "_model_len"}, 64'(m_q.size()), 64'(len));
  endtask

  initial begin
    int d0;
    logic [7:0] b;
    logic       sv;
    logic       ack;

    rst_n = 1'b0;
    scan_valid = 1'b0;
    scan_byte = 8'h00;
    word_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset", 0, 64'h0, 1'b0);
    check("reset_drop", 64'(key_drop), 64'h0);
    check("reset_dig", 64'({dig2, dig1}), 64'h0);
    #1 rst_n = 1'b1;

    // Make/break sequence: a, b, ENTR with releases in between.
    sendKey(8'h1C); applyStimulus(1'b1, 8'hF0, 1'b0); applyStimulus(1'b1, 8'h1C, 1'b0);
    sendKey(8'h32); applyStimulus(1'b1, 8'hF0, 1'b0); applyStimulus(1'b1, 8'h32, 1'b0);
    sendKey(8'h5A); applyStimulus(1'b1, 8'hF0, 1'b0); applyStimulus(1'b1, 8'h5A, 1'b0);
    settle();
    checkOutput("makebreak", 2, 64'h20, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    settle();
    checkOutput("ack", 0, 64'h0, 1'b0);

    // Overflow: the ninth letter is dropped and entry 7 keeps the eighth (h = 7).
    d0 = drop_count;
    for (int i = 0; i < 9; i++) sendKey(letters[i % 8]);
    settle();
    check("ovf_len", 64'(word_len), 64'd8);
    check("ovf_entry7", 64'(word_data[39:35]), 64'd7);
    check("ovf_drops", 64'(drop_count - d0), 64'd1);
    check("ovf_model_len", 64'(m_q.size()), 64'd8);
    sendKey(8'h5A); settle();
    applyStimulus(1'b0, 8'h00, 1'b1); settle();

    // Backspace down to empty and once more on an empty buffer.
    sendKey(8'h1C); sendKey(8'h32);
    applyStimulus(1'b1, 8'h66, 1'b0);
    settle();
    checkOutput("bksp1", 1, 64'h0, 1'b0);
    d0 = drop_count;
    applyStimulus(1'b1, 8'h66, 1'b0); applyStimulus(1'b1, 8'h66, 1'b0);
    settle();
    checkOutput("bksp2", 0, 64'h0, 1'b0);
    check("bksp_drops", 64'(drop_count - d0), 64'd0);

    // Extended and unmapped keys leave the word alone.
    sendKey(8'h21); settle();
    d0 = drop_count;
    applyStimulus(1'b1, 8'hE0, 1'b0); applyStimulus(1'b1, 8'h75, 1'b0);
    applyStimulus(1'b1, 8'hE0, 1'b0); applyStimulus(1'b1, 8'hF0, 1'b0);
    applyStimulus(1'b1, 8'h75, 1'b0);
    sendKey(8'h76); settle();
    checkOutput("ext", 1, 64'h2, 1'b0);
    check("ext_drops", 64'(drop_count - d0), 64'd0);
    check("ext_dig", 64'({dig2, dig1}), 64'h76);

    // Pending word: letter and ENTR both dropped; a stray ack is ignored.
    sendKey(8'h5A); settle();
    checkOutput("commit", 1, 64'h2, 1'b1);
    d0 = drop_count;
    sendKey(8'h23); sendKey(8'h5A); settle();
    checkOutput("pending", 1, 64'h2, 1'b1);
    check("pending_drops", 64'(drop_count - d0), 64'd2);
    applyStimulus(1'b0, 8'h00, 1'b1); settle();
    sendKey(8'h24); settle();
    applyStimulus(1'b0, 8'h00, 1'b1); settle();
    checkOutput("stray_ack", 1, 64'h4, 1'b0);

    // Reset while a lookup is in progress with three letters buffered.
    sendKey(8'h1C); sendKey(8'h32); settle();
    check("pre_reset_len", 64'(word_len), 64'd3);
    applyStimulus(1'b1, 8'h21, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    scan_valid = 1'b0;
    #1;
    checkOutput("async_reset", 0, 64'h0, 1'b0);
    check("async_reset_dig", 64'({dig2, dig1}), 64'h0);
    check("async_reset_drop", 64'(key_drop), 64'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    sendKey(8'h1C); settle();
    checkOutput("post_reset", 1, 64'h0, 1'b0);
    check("post_reset_dig", 64'({dig2, dig1}), 64'h1C);

    // Random traffic, including bytes that collide with lookup cycles.
    for (int n = 0; n < 3000; n++) begin
      int pick;
      pick = int'($urandom_range(0, 15));
      sv = ($urandom_range(0, 9) < 6);
      ack = ($urandom_range(0, 9) == 0);
      if (pick < 8) b = letters[pick];
      else if (pick == 8) b = 8'h5A;
      else if (pick == 9) b = 8'h66;
      else if (pick == 10) b = 8'hF0;
      else if (pick == 11) b = 8'hE0;
      else if (pick == 12) b = 8'h76;
      else if (pick == 13) b = ($urandom_range(0, 1) == 0) ? 8'h0E : 8'h16;
      else b = 8'($urandom_range(0, 255));
      applyStimulus(sv, b, ack);
    end
    settle();
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
